// File: rtl/fp_int_pkg.sv
// Shared types and defaults for the FP16 x INT bit-serial multiplier and its controller.
package fp_int_pkg;

    localparam int unsigned ACT_WIDTH_DEF = 16;
    localparam int unsigned PRECISION_DEF = 4;
    localparam int unsigned MAX_OUT_DEF   = 4;

    // FP16 field layout, shared with fp_int_mul
    localparam int unsigned FP16_SIGN_W = 1;
    localparam int unsigned FP16_EXP_W  = 5;
    localparam int unsigned FP16_MAN_W  = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERIAL = 2'd1,
        DRAIN  = 2'd2
    } state_t;

endpackage

// File: rtl/fp_int_flag_fifo.sv
// 1-bit synchronous FIFO holding the dot-product "last" flag of each in-flight operand.
module fp_int_flag_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic empty,
    output logic full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_int_mul_ctrl.sv
// Sequencer feeding fp_int_mul one weight bit per cycle (MSB first) and tagging
// returning results with the dot-product last flag.
module fp_int_mul_ctrl
    import fp_int_pkg::*;
#(
    parameter int unsigned PRECISION = PRECISION_DEF,
    parameter int unsigned ACT_WIDTH = ACT_WIDTH_DEF,
    parameter int unsigned MAX_OUT   = MAX_OUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ACT_WIDTH-1:0] in_act,
    input  logic [PRECISION-1:0] in_w,
    input  logic                 in_last,
    output logic                 mul_valid,
    output logic [ACT_WIDTH-1:0] mul_act,
    output logic                 mul_w,
    input  logic                 mul_start_acc,
    output logic                 acc_valid,
    output logic                 acc_last,
    output logic                 done,
    output logic                 busy,
    output logic                 err
);

    localparam int unsigned   CW      = $clog2(MAX_OUT + 1);
    localparam int unsigned   BW      = $clog2(PRECISION);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);
    localparam logic [BW-1:0] TOP_BIT = BW'(PRECISION - 1);

    state_t               state;
    state_t               state_nxt;
    logic [BW-1:0]        bit_cnt;
    logic [ACT_WIDTH-1:0] act_reg;
    logic [PRECISION-1:0] w_reg;
    logic                 last_reg;
    logic [CW-1:0]        outstanding;
    logic                 accept;
    logic                 ret_ok;
    logic                 room;
    logic                 last_bit;
    logic                 fifo_dout;
    logic                 fifo_empty;
    logic                 fifo_full;

    // FIFO flags also guard against push-on-full / pop-on-empty
    assign last_bit = (bit_cnt == '0);
    assign room     = (outstanding < MAX_CNT) && !fifo_full;
    assign accept   = in_valid && in_ready;
    assign ret_ok   = mul_start_acc && (outstanding != '0) && !fifo_empty;
    assign mul_act  = act_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = SERIAL;
            SERIAL:  if (last_bit && !accept) state_nxt = last_reg ? DRAIN : IDLE;
            DRAIN:   if (acc_valid && acc_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        mul_valid = 1'b0;
        mul_w     = 1'b0;
        unique case (state)
            IDLE: in_ready = room;
            SERIAL: begin
                mul_valid = 1'b1;
                mul_w     = w_reg[bit_cnt];
                in_ready  = last_bit && !last_reg && room;
            end
            default: ;
        endcase
        if (!rst) in_ready = 1'b0;
        busy = (state != IDLE) || (outstanding != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_reg     <= '0;
            w_reg       <= '0;
            last_reg    <= 1'b0;
            bit_cnt     <= '0;
            outstanding <= '0;
            acc_valid   <= 1'b0;
            acc_last    <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            if (accept) begin
                act_reg  <= in_act;
                w_reg    <= in_w;
                last_reg <= in_last;
                bit_cnt  <= TOP_BIT;
            end else if (state == SERIAL && !last_bit) begin
                bit_cnt <= bit_cnt - 1'b1;
            end
            if (accept && !ret_ok) begin
                outstanding <= outstanding + 1'b1;
            end else if (!accept && ret_ok) begin
                outstanding <= outstanding - 1'b1;
            end
            acc_valid <= ret_ok;
            acc_last  <= ret_ok && fifo_dout;
            done      <= (state == DRAIN) && acc_valid && acc_last;
            if (mul_start_acc && !ret_ok) begin
                err <= 1'b1;
            end
        end
    end

    fp_int_flag_fifo #(
        .DEPTH (MAX_OUT)
    ) u_flag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (ret_ok),
        .din   (in_last),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule

// File: doc/fp_int_mul_ctrl.md
# fp_int_mul_ctrl

Sequencing controller for the bit-serial FP16 × INT multiplier `fp_int_mul`. It accepts (activation, PRECISION-bit weight) operand pairs over a valid/ready handshake and drives the multiplier's `act`/`w`/`valid` inputs one weight bit per cycle, MSB first. It tracks outstanding products and tags each returning `start_acc` result with a dot-product "last" flag for the downstream accumulator. It sits between the operand fetch logic and `fp_int_mul`.

## Interface
- `PRECISION`, 4, weight bits per operand (≥2)
- `ACT_WIDTH`, 16, activation width (FP16)
- `MAX_OUT`, 4, max in-flight operands (issued, result not yet returned); power of 2
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-low
- `in_valid`  in  1  operand pair offered
- `in_ready`  out  1  controller accepts this cycle
- `in_act`  in  ACT_WIDTH  activation
- `in_w`  in  PRECISION  two's-complement weight
- `in_last`  in  1  final operand of the dot product
- `mul_valid`  out  1  to `fp_int_mul.valid`
- `mul_act`  out  ACT_WIDTH  to `fp_int_mul.act`
- `mul_w`  out  1  to `fp_int_mul.w`
- `mul_start_acc`  in  1  from `fp_int_mul.start_acc`; each high cycle = one result
- `acc_valid`  out  1  result forwarded to accumulator
- `acc_last`  out  1  qualifies `acc_valid`: this is the dot product's last result
- `done`  out  1  one-cycle pulse, dot product complete
- `busy`  out  1  state ≠ IDLE or outstanding ≠ 0
- `err`  out  1  sticky: `mul_start_acc` with zero outstanding

## Operation
- States: IDLE, SERIAL, DRAIN.
- IDLE: `in_ready`=1 if outstanding < MAX_OUT. Accept → load act/w shift register, bit_cnt=PRECISION-1, latch last flag → SERIAL.
- SERIAL: `mul_valid`=1, `mul_act`=latched act, `mul_w`=w[bit_cnt]; bit_cnt decrements each cycle.
- On bit_cnt==0 cycle: `in_ready`=1 if outstanding < MAX_OUT and latched last=0. Accept → reload, stay SERIAL (back-to-back, `mul_valid` stays high). No accept and last=0 → IDLE. Latched last=1 → DRAIN.
- In all other SERIAL cycles and in DRAIN, `in_ready`=0.
- DRAIN: wait for results; on `acc_valid && acc_last` → `done` pulse next cycle, → IDLE.
- Outstanding counter: +1 on accept, −1 on `mul_start_acc`; both same cycle → unchanged. `mul_start_acc` at zero → set `err`, counter holds at 0, no `acc_valid`.
- Last-flag FIFO (depth MAX_OUT): push `in_last` on accept, pop on valid `mul_start_acc`; popped flag becomes `acc_last`.
- Results return in issue order; no reordering.

## Timing
- Reset (async assert, sync release): state IDLE, `in_ready`=0 during reset, `mul_valid`/`mul_w`/`acc_valid`/`acc_last`/`done`/`busy`/`err`=0, `mul_act`=0, counter and FIFO cleared. First cycle after release: `in_ready`=1.
- Accept at edge k: `mul_valid`=1, `mul_w`=in_w[PRECISION-1] during cycle k+1; last bit (in_w[0]) in cycle k+PRECISION.
- Back-to-back issue: one operand per PRECISION cycles, no valid gap.
- `acc_valid`/`acc_last` registered: high the cycle after `mul_start_acc`.
- `done` one cycle after the `acc_last` result, i.e. two cycles after the final `mul_start_acc`.
- Reset mid-operation: all in-flight state discarded; results arriving after release flag `err`.
- `in_act`/`in_w`/`in_last` sampled only on accept; changes otherwise ignored.

## Structure
- Package `fp_int_pkg`: ACT_WIDTH/PRECISION defaults, state enum (IDLE/SERIAL/DRAIN), FP16 field widths shared with `fp_int_mul`.
- Sub-module `fp_int_flag_fifo`: 1-bit synchronous FIFO, depth MAX_OUT, push/pop/empty/full, async active-low reset.
- Counter width clog2(MAX_OUT+1); bit_cnt width clog2(PRECISION).

## Test plan
- Single op: act=16'h1234, w=4'b0101, last=1 → `mul_w` 0,1,0,1 over cycles k+1..k+4, `mul_act`=16'h1234 held; model `start_acc` → `acc_valid`+`acc_last`, then `done`.
- Back-to-back: w=4'b1100 then 4'b0011 (act 16'hf234), in_valid held → `mul_valid` high 8 continuous cycles, `mul_w` 1,1,0,0,0,0,1,1.
- Backpressure: MAX_OUT=2, no `start_acc` returned → `in_ready` low after 2nd accept; one `start_acc` → ready reasserts on next bit_cnt==0/IDLE.
- Last/DRAIN: 3 ops, last on 3rd → `in_ready`=0 until `done`; `acc_last`=1 only on the 3rd result.
- Spurious `mul_start_acc` in IDLE → `err`=1 sticky, no `acc_valid`, counter stays 0.
- Reset asserted mid-SERIAL (bit_cnt=2) → all outputs 0 immediately; after release `in_ready`=1, `busy`=0.
